bool_lut: RTL and testbench
===========================

BOOL_LUT -- requirements
Module: bool_lut

Interface
REQ-001 Parameter: N_IN, default 4, number of Boolean inputs; legal range 1..8; truth table depth TT = 2**N_IN.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_vec  input  N_IN  live operand; bit0 = a, bit1 = b, bit2 = c, bit3 = d, and so on; table index = in_vec.
REQ-005 in_valid  input  1  request evaluation of in_vec.
REQ-006 cfg_bit  input  1  serial truth-table data bit.
REQ-007 cfg_valid  input  1  cfg_bit is valid.
REQ-008 cfg_ready  output  1  block accepts cfg_bit this cycle.
REQ-009 sweep_start  input  1  request exhaustive evaluation of all TT minterms.
REQ-010 z  output  1  registered function result.
REQ-011 z_valid  output  1  z is new this cycle.
REQ-012 sweep_idx  output  N_IN  minterm index that produced z during a sweep; 0 outside a sweep.
REQ-013 sweep_busy  output  1  sweep in progress.
REQ-014 sweep_done  output  1  one-cycle pulse at sweep completion.
REQ-015 ones_count  output  N_IN+1  number of minterms with z=1 counted by the last sweep.
REQ-016 tt_loaded  output  1  complete truth table has been loaded since reset.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD and SWEEP.
REQ-018 cfg_ready SHALL be 1 in IDLE and LOAD, and 0 in SWEEP.
REQ-019 Each cycle with cfg_valid=1 and cfg_ready=1 SHALL write cfg_bit to table[load_ptr] and increment load_ptr; the first bit written is index 0.
REQ-020 Accepting a bit in IDLE SHALL enter LOAD.
REQ-021 Accepting bit TT-1 SHALL set tt_loaded=1, wrap load_ptr to 0 and return to IDLE.
REQ-022 Gaps in cfg_valid during LOAD SHALL be allowed; state and load_ptr hold.
REQ-023 In IDLE, in_valid=1 SHALL produce z=table[in_vec] and z_valid=1 on the next cycle (latency 1).
REQ-024 In IDLE, if in_valid=0, z_valid SHALL be 0 on the next cycle and z SHALL hold its value.
REQ-025 If in_valid and an accepted cfg write coincide in IDLE, the evaluation SHALL use the table contents before that write.
REQ-026 in_valid SHALL be ignored in LOAD and SWEEP.
REQ-027 In IDLE, sweep_start=1 with cfg_valid=0 SHALL enter SWEEP and clear ones_count to 0.
REQ-028 If cfg_valid=1 and sweep_start=1 coincide in IDLE, cfg SHALL win and sweep_start SHALL be dropped.
REQ-029 sweep_start SHALL be ignored in LOAD and SWEEP.
REQ-030 SWEEP SHALL evaluate one index per cycle, 0 through TT-1.
REQ-031 z_valid SHALL be 1 for exactly TT consecutive cycles beginning the cycle after sweep_start is accepted, with sweep_idx=k alongside the result of index k.
REQ-032 sweep_busy SHALL be 1 on exactly those TT cycles.
REQ-033 ones_count SHALL increment in the cycle after each z=1 of the sweep, with no overflow since the maximum is TT.
REQ-034 sweep_done SHALL pulse 1 for one cycle, the cycle after the last sweep z_valid; ones_count is final in that cycle and the FSM is back in IDLE.
REQ-035 ones_count SHALL hold until the next accepted sweep_start or reset.
REQ-036 A sweep with tt_loaded=0 SHALL still run, using the current table contents (zeros plus any partial load).

Reset
REQ-037 rst_n=0 SHALL asynchronously force the FSM to IDLE, the table to all zeros, and load_ptr to 0.
REQ-038 rst_n=0 SHALL asynchronously force z, z_valid, sweep_idx, sweep_busy, sweep_done, ones_count and tt_loaded to 0.
REQ-039 Reset mid-LOAD or mid-SWEEP SHALL abort the operation with no completion pulse.
REQ-040 Reset release SHALL be synchronous to clk; first action is allowed on the first edge after release.

Structure
REQ-041 Package bool_lut_pkg SHALL hold the state enum and the N_IN default constant.
REQ-042 Sub-module bool_lut_table SHALL hold the TT-bit storage: write port (ptr, bit, en) and read mux by index.
REQ-043 The top level SHALL hold the FSM, counters and output registers.

Verification (N_IN=4, table for z=(a&b)|(c&d) = 16'hF888)
REQ-044 Reset then in_vec=4'hF, in_valid=1 -> next cycle z=0, z_valid=1; tt_loaded=0.
REQ-045 Load F888 LSB-first with two idle gaps -> tt_loaded=1 after the 16th bit; in_vec=3 -> z=1; in_vec=5 -> z=0; in_vec=12 -> z=1.
REQ-046 sweep_start -> 16 cycles of z_valid with sweep_idx 0..15 and z matching F888; sweep_done once; ones_count=7.
REQ-047 cfg_valid and sweep_start together in IDLE -> bit loaded, no sweep, sweep_busy stays 0; in_valid in the same cycle evaluates the old table.
REQ-048 rst_n low at the 8th sweep cycle -> all outputs 0 immediately, no sweep_done, table cleared.
REQ-049 in_valid and sweep_start pulses during SWEEP -> ignored; sweep length stays 16 cycles.

Source files
------------

// File: rtl/bool_lut_pkg.sv
// Shared types and defaults for the serially loaded Boolean look-up table.
package bool_lut_pkg;

    localparam int N_IN_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

endpackage

// File: rtl/bool_lut_table.sv
// Truth-table storage: single-bit write port addressed by pointer, combinational read by index.
module bool_lut_table
    import bool_lut_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [N_IN-1:0] wr_ptr,
    input  logic            wr_bit,
    input  logic [N_IN-1:0] rd_idx,
    output logic            rd_bit
);

    localparam int TT = 2 ** N_IN;

    logic [TT-1:0] mem_reg;
    logic [TT-1:0] wr_sel;

    genvar gi;
    generate
        for (gi = 0; gi < TT; gi++) begin : g_sel
            assign wr_sel[gi] = wr_en && (wr_ptr == N_IN'(gi));
        end
    endgenerate

    // Reset must clear the whole table, so this stays in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg <= '0;
        end else begin
            mem_reg <= (mem_reg & ~wr_sel) | (wr_sel & {TT{wr_bit}});
        end
    end

    assign rd_bit = mem_reg[rd_idx];

endmodule

// File: rtl/bool_lut.sv
// Boolean function evaluator: serial truth-table load, single evaluations and full minterm sweeps.
module bool_lut
    import bool_lut_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] in_vec,
    input  logic            in_valid,
    input  logic            cfg_bit,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic            sweep_start,
    output logic            z,
    output logic            z_valid,
    output logic [N_IN-1:0] sweep_idx,
    output logic            sweep_busy,
    output logic            sweep_done,
    output logic [N_IN:0]   ones_count,
    output logic            tt_loaded
);

    localparam logic [N_IN-1:0] LAST_IDX = '1;

    state_t          state_reg, state_next;
    logic [N_IN-1:0] load_ptr_reg, load_ptr_next;
    logic            z_reg, z_next;
    logic            z_valid_reg, z_valid_next;
    logic [N_IN-1:0] sweep_idx_reg, sweep_idx_next;
    logic            sweep_busy_reg, sweep_busy_next;
    logic            sweep_done_reg, sweep_done_next;
    logic [N_IN:0]   ones_count_reg, ones_count_next;
    logic            tt_loaded_reg, tt_loaded_next;

    logic            cfg_accept;
    logic            sweep_accept;
    logic [N_IN-1:0] rd_idx;
    logic            rd_bit;

    assign cfg_ready    = (state_reg != SWEEP);
    assign cfg_accept   = cfg_valid && cfg_ready;
    // A configuration write always beats a sweep request in the same cycle.
    assign sweep_accept = (state_reg == IDLE) && sweep_start && !cfg_valid;

    always_comb begin
        rd_idx = in_vec;
        if (state_reg == SWEEP) begin
            rd_idx = sweep_idx_reg + N_IN'(1);
        end else if (sweep_accept) begin
            rd_idx = '0;
        end
    end

    bool_lut_table #(.N_IN(N_IN)) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (cfg_accept),
        .wr_ptr (load_ptr_reg),
        .wr_bit (cfg_bit),
        .rd_idx (rd_idx),
        .rd_bit (rd_bit)
    );

    always_comb begin
        state_next      = state_reg;
        load_ptr_next   = load_ptr_reg;
        z_next          = z_reg;
        z_valid_next    = 1'b0;
        sweep_idx_next  = '0;
        sweep_busy_next = 1'b0;
        sweep_done_next = 1'b0;
        ones_count_next = ones_count_reg;
        tt_loaded_next  = tt_loaded_reg;

        if (cfg_accept) begin
            if (load_ptr_reg == LAST_IDX) begin
                load_ptr_next  = '0;
                tt_loaded_next = 1'b1;
                state_next     = IDLE;
            end else begin
                load_ptr_next  = load_ptr_reg + N_IN'(1);
                state_next     = LOAD;
            end
        end

        case (state_reg)
            IDLE: begin
                if (sweep_accept) begin
                    state_next      = SWEEP;
                    z_next          = rd_bit;
                    z_valid_next    = 1'b1;
                    sweep_busy_next = 1'b1;
                    ones_count_next = '0;
                end else if (in_valid) begin
                    z_next       = rd_bit;
                    z_valid_next = 1'b1;
                end
            end
            LOAD: begin
            end
            SWEEP: begin
                // z_reg holds the result presented this cycle; count it on the way out.
                ones_count_next = ones_count_reg + (N_IN + 1)'(z_reg);
                if (sweep_idx_reg == LAST_IDX) begin
                    state_next      = IDLE;
                    sweep_done_next = 1'b1;
                end else begin
                    z_next          = rd_bit;
                    z_valid_next    = 1'b1;
                    sweep_idx_next  = sweep_idx_reg + N_IN'(1);
                    sweep_busy_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            load_ptr_reg   <= '0;
            z_reg          <= 1'b0;
            z_valid_reg    <= 1'b0;
            sweep_idx_reg  <= '0;
            sweep_busy_reg <= 1'b0;
            sweep_done_reg <= 1'b0;
            ones_count_reg <= '0;
            tt_loaded_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            load_ptr_reg   <= load_ptr_next;
            z_reg          <= z_next;
            z_valid_reg    <= z_valid_next;
            sweep_idx_reg  <= sweep_idx_next;
            sweep_busy_reg <= sweep_busy_next;
            sweep_done_reg <= sweep_done_next;
            ones_count_reg <= ones_count_next;
            tt_loaded_reg  <= tt_loaded_next;
        end
    end

    assign z          = z_reg;
    assign z_valid    = z_valid_reg;
    assign sweep_idx  = sweep_idx_reg;
    assign sweep_busy = sweep_busy_reg;
    assign sweep_done = sweep_done_reg;
    assign ones_count = ones_count_reg;
    assign tt_loaded  = tt_loaded_reg;

endmodule

// File: tb/tb_bool_lut.sv
// Directed bench for bool_lut with N_IN=4 and the table of z=(a&b)|(c&d) = 16'hF888.
module tb_bool_lut;

    localparam int N = 4;
    localparam logic [15:0] TT_F888 = 16'hF888;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_vec = '0;
    logic         in_valid = 1'b0;
    logic         cfg_bit = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic         sweep_start = 1'b0;
    logic         z;
    logic         z_valid;
    logic [N-1:0] sweep_idx;
    logic         sweep_busy;
    logic         sweep_done;
    logic [N:0]   ones_count;
    logic         tt_loaded;

    int checks = 0;
    int errors = 0;

    bool_lut #(.N_IN(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vec      (in_vec),
        .in_valid    (in_valid),
        .cfg_bit     (cfg_bit),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .sweep_start (sweep_start),
        .z           (z),
        .z_valid     (z_valid),
        .sweep_idx   (sweep_idx),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .ones_count  (ones_count),
        .tt_loaded   (tt_loaded)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({z, z_valid, sweep_idx, sweep_busy, sweep_done, ones_count, tt_loaded} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got z=%0b zv=%0b idx=%0d busy=%0b done=%0b ones=%0d tl=%0b want all 0",
                     z, z_valid, sweep_idx, sweep_busy, sweep_done, ones_count, tt_loaded);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cfg_ready got %0b want 1", cfg_ready);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_vec   = 4'hF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        $display("eval in_vec=%0h z=%0b z_valid=%0b tt_loaded=%0b", 4'hF, z, z_valid, tt_loaded);
        checks++;
        if ({z, z_valid, tt_loaded} !== 3'b010) begin
            errors++;
            $display("FAIL empty_eval got z=%0b zv=%0b tl=%0b want z=0 zv=1 tl=0", z, z_valid, tt_loaded);
        end
    endtask

    task automatic test_load();
        logic [3:0] vecs [3] = '{4'd3, 4'd5, 4'd12};
        logic       exps [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            if (i == 5 || i == 11) begin
                // gap cycle: evaluation and sweep requests must be ignored mid-load
                cfg_valid   = 1'b0;
                in_valid    = 1'b1;
                in_vec      = 4'd3;
                sweep_start = 1'b1;
                step();
                in_valid    = 1'b0;
                sweep_start = 1'b0;
                checks++;
                if ({z_valid, sweep_busy, cfg_ready} !== 3'b001) begin
                    errors++;
                    $display("FAIL load_gap%0d got zv=%0b busy=%0b rdy=%0b want zv=0 busy=0 rdy=1",
                             i, z_valid, sweep_busy, cfg_ready);
                end
            end
            cfg_valid = 1'b1;
            cfg_bit   = TT_F888[i];
            step();
            $display("load bit%0d=%0b tt_loaded=%0b", i, TT_F888[i], tt_loaded);
            checks++;
            if (tt_loaded !== (i == 15)) begin
                errors++;
                $display("FAIL load_tt_loaded bit%0d got %0b want %0b", i, tt_loaded, (i == 15));
            end
        end
        cfg_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_vec   = vecs[j];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            $display("eval in_vec=%0d z=%0b z_valid=%0b", vecs[j], z, z_valid);
            checks++;
            if ({z, z_valid} !== {exps[j], 1'b1}) begin
                errors++;
                $display("FAIL eval_%0d got z=%0b zv=%0b want z=%0b zv=1", vecs[j], z, z_valid, exps[j]);
            end
        end
        in_vec = 4'd0;
        step();
        checks++;
        if ({z, z_valid} !== 2'b10) begin
            errors++;
            $display("FAIL eval_hold got z=%0b zv=%0b want z=1 zv=0", z, z_valid);
        end
    endtask

    task automatic test_sweep(input logic [15:0] exp_tt, input int exp_ones, input bit inject);
        int run = 0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            $display("sweep idx=%0d z=%0b ones=%0d busy=%0b", sweep_idx, z, ones_count, sweep_busy);
            checks++;
            if ({z_valid, sweep_busy, sweep_done, cfg_ready} !== 4'b1100 || sweep_idx !== k[3:0]
                || z !== exp_tt[k] || ones_count !== run[4:0]) begin
                errors++;
                $display("FAIL sweep_k%0d got zv=%0b busy=%0b done=%0b rdy=%0b idx=%0d z=%0b ones=%0d want zv=1 busy=1 done=0 rdy=0 idx=%0d z=%0b ones=%0d",
                         k, z_valid, sweep_busy, sweep_done, cfg_ready, sweep_idx, z, ones_count, k, exp_tt[k], run);
            end
            if (exp_tt[k]) run++;
            if (inject && (k == 3 || k == 9)) begin
                in_valid    = 1'b1;
                in_vec      = k[3:0];
                sweep_start = 1'b1;
            end else begin
                in_valid    = 1'b0;
                sweep_start = 1'b0;
            end
            step();
        end
        in_valid    = 1'b0;
        sweep_start = 1'b0;
        $display("sweep end done=%0b ones=%0d busy=%0b", sweep_done, ones_count, sweep_busy);
        checks++;
        if ({sweep_done, sweep_busy, z_valid, cfg_ready} !== 4'b1001 || ones_count !== exp_ones[4:0]
            || sweep_idx !== 4'd0) begin
            errors++;
            $display("FAIL sweep_done got done=%0b busy=%0b zv=%0b rdy=%0b ones=%0d idx=%0d want done=1 busy=0 zv=0 rdy=1 ones=%0d idx=0",
                     sweep_done, sweep_busy, z_valid, cfg_ready, ones_count, sweep_idx, exp_ones);
        end
        step();
        checks++;
        if (sweep_done !== 1'b0 || ones_count !== exp_ones[4:0]) begin
            errors++;
            $display("FAIL sweep_after got done=%0b ones=%0d want done=0 ones=%0d", sweep_done, ones_count, exp_ones);
        end
    endtask

    task automatic test_coincide();
        cfg_valid   = 1'b1;
        cfg_bit     = 1'b1;
        sweep_start = 1'b1;
        in_valid    = 1'b1;
        in_vec      = 4'd0;
        step();
        cfg_valid   = 1'b0;
        sweep_start = 1'b0;
        in_valid    = 1'b0;
        $display("coincide z=%0b z_valid=%0b busy=%0b", z, z_valid, sweep_busy);
        checks++;
        if ({z, z_valid, sweep_busy} !== 3'b010) begin
            errors++;
            $display("FAIL coincide_eval got z=%0b zv=%0b busy=%0b want z=0 zv=1 busy=0", z, z_valid, sweep_busy);
        end
        step();
        checks++;
        if ({sweep_busy, z_valid, cfg_ready} !== 3'b001) begin
            errors++;
            $display("FAIL coincide_nosweep got busy=%0b zv=%0b rdy=%0b want busy=0 zv=0 rdy=1", sweep_busy, z_valid, cfg_ready);
        end
        for (int i = 1; i < 16; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = TT_F888[i];
            step();
        end
        cfg_valid = 1'b0;
        in_vec    = 4'd0;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        $display("eval in_vec=0 z=%0b z_valid=%0b", z, z_valid);
        checks++;
        if ({z, z_valid} !== 2'b11) begin
            errors++;
            $display("FAIL coincide_bit_written got z=%0b zv=%0b want z=1 zv=1", z, z_valid);
        end
    endtask

    task automatic test_reset_mid_sweep();
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        repeat (7) step();
        checks++;
        if (sweep_busy !== 1'b1 || sweep_idx !== 4'd7) begin
            errors++;
            $display("FAIL midsweep_pre got busy=%0b idx=%0d want busy=1 idx=7", sweep_busy, sweep_idx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({z, z_valid, sweep_idx, sweep_busy, sweep_done, ones_count, tt_loaded} !== '0) begin
            errors++;
            $display("FAIL midsweep_reset got z=%0b zv=%0b idx=%0d busy=%0b done=%0b ones=%0d tl=%0b want all 0",
                     z, z_valid, sweep_idx, sweep_busy, sweep_done, ones_count, tt_loaded);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if ({sweep_done, sweep_busy} !== 2'b00) begin
                errors++;
                $display("FAIL midsweep_nodone cyc%0d got done=%0b busy=%0b want 0 0", c, sweep_done, sweep_busy);
            end
        end
        in_vec   = 4'd12;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        $display("eval in_vec=12 z=%0b z_valid=%0b", z, z_valid);
        checks++;
        if ({z, z_valid, tt_loaded} !== 3'b010) begin
            errors++;
            $display("FAIL midsweep_table_cleared got z=%0b zv=%0b tl=%0b want z=0 zv=1 tl=0", z, z_valid, tt_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_sweep(TT_F888, 7, 1'b0);
        test_sweep(TT_F888, 7, 1'b1);
        test_coincide();
        test_sweep(TT_F888 | 16'h0001, 8, 1'b0);
        test_reset_mid_sweep();
        test_sweep(16'h0000, 0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
